// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin arbiter sharing one synchronous RAM between two
// requesters, with locked bursts capped at MAX_BURST consecutive grants.
module ram_arbiter #(
  parameter int unsigned data_width = 32,
  parameter int unsigned addr_width = 4,
  parameter int unsigned MAX_BURST  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic                  lock0,
  input  logic                  lock1,
  input  logic [addr_width-1:0] addr0,
  input  logic [addr_width-1:0] addr1,
  input  logic [data_width-1:0] wdata0,
  input  logic [data_width-1:0] wdata1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [data_width-1:0] rdata,
  output logic [addr_width-1:0] ram_read_address,
  output logic [addr_width-1:0] ram_write_address,
  output logic                  ram_write,
  output logic [data_width-1:0] ram_din,
  input  logic [data_width-1:0] ram_dout
);

  typedef enum logic [1:0] {StIdle, StOwn0, StOwn1} state_e;

  localparam logic [3:0] MaxBurst = 4'(MAX_BURST);

  state_e     state_q, state_d;
  logic       prio_q, prio_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] burst_cnt;

  // Grant selection; an owner holding req+lock wins outright, else round-robin.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      if (state_q == StOwn0 && req0 && lock0) begin
        gnt0 = 1'b1;
      end else if (state_q == StOwn1 && req1 && lock1) begin
        gnt1 = 1'b1;
      end else if (req0 && req1) begin
        gnt0 = ~prio_q;
        gnt1 = prio_q;
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
  end

  // Next state, priority and burst count from this cycle's grant.
  always_comb begin
    state_d   = StIdle;
    cnt_d     = 4'd0;
    prio_d    = prio_q;
    burst_cnt = 4'd1;
    if (gnt0) begin
      prio_d    = 1'b1;
      burst_cnt = (state_q == StOwn0) ? cnt_q + 4'd1 : 4'd1;
      if (lock0 && burst_cnt < MaxBurst) begin
        state_d = StOwn0;
        cnt_d   = burst_cnt;
      end
    end else if (gnt1) begin
      prio_d    = 1'b0;
      burst_cnt = (state_q == StOwn1) ? cnt_q + 4'd1 : 4'd1;
      if (lock1 && burst_cnt < MaxBurst) begin
        state_d = StOwn1;
        cnt_d   = burst_cnt;
      end
    end
  end

  // Route the granted port onto the RAM; all zeros when nobody is granted.
  always_comb begin
    ram_read_address  = '0;
    ram_write_address = '0;
    ram_din           = '0;
    ram_write         = 1'b0;
    if (gnt0) begin
      ram_read_address  = addr0;
      ram_write_address = addr0;
      ram_din           = wdata0;
      ram_write         = we0;
    end else if (gnt1) begin
      ram_read_address  = addr1;
      ram_write_address = addr1;
      ram_din           = wdata1;
      ram_write         = we1;
    end
  end

  assign rdata = ram_dout;

  // FSM, priority, burst counter and read-valid strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      prio_q  <= 1'b0;
      cnt_q   <= 4'd0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      cnt_q   <= cnt_d;
      rvalid0 <= gnt0 & ~we0;
      rvalid1 <= gnt1 & ~we1;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural registered-read RAM.
module tb_ram_arbiter;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 4;

  logic          clk;
  logic          rst;
  logic          req0, req1, we0, we1, lock0, lock1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1;
  logic [DW-1:0] rdata;
  logic [AW-1:0] ram_read_address, ram_write_address;
  logic          ram_write;
  logic [DW-1:0] ram_din, ram_dout;

  logic          mem_init;
  logic [DW-1:0] mem [16];

  int n_tests = 0;
  int n_fail  = 0;
  int burst_exp [6] = '{1, 1, 1, 1, 0, 1};

  ram_arbiter #(
    .data_width(DW),
    .addr_width(AW),
    .MAX_BURST (4)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .req0             (req0),
    .req1             (req1),
    .we0              (we0),
    .we1              (we1),
    .lock0            (lock0),
    .lock1            (lock1),
    .addr0            (addr0),
    .addr1            (addr1),
    .wdata0           (wdata0),
    .wdata1           (wdata1),
    .gnt0             (gnt0),
    .gnt1             (gnt1),
    .rvalid0          (rvalid0),
    .rvalid1          (rvalid1),
    .rdata            (rdata),
    .ram_read_address (ram_read_address),
    .ram_write_address(ram_write_address),
    .ram_write        (ram_write),
    .ram_din          (ram_din),
    .ram_dout         (ram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: memory word i preloads to i+10, read data registered.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 16; i++) mem[i] <= DW'(i + 10);
    end else if (ram_write) begin
      mem[ram_write_address] <= ram_din;
    end
    ram_dout <= mem[ram_read_address];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic drop_all();
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0; lock0 = 1'b0; lock1 = 1'b0;
  endtask

  initial begin
    drop_all();
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    mem_init = 1'b1;
    rst = 1'b1;
    // Request during reset must not be granted.
    req0 = 1'b1;
    @(negedge clk);
    check("rst_gnt0", 32'(gnt0), 32'd0);
    check("rst_ram_write", 32'(ram_write), 32'd0);
    next_cycle();
    mem_init = 1'b0;
    rst = 1'b0;
    req0 = 1'b0;
    @(negedge clk);
    check("rst_rvalid0", 32'(rvalid0), 32'd0);
    check("rst_rvalid1", 32'(rvalid1), 32'd0);
    next_cycle();

    // Reset then read addr 3.
    req0 = 1'b1; addr0 = 4'd3;
    @(negedge clk);
    check("rd_gnt0", 32'(gnt0), 32'd1);
    check("rd_gnt1", 32'(gnt1), 32'd0);
    check("rd_addr", 32'(ram_read_address), 32'd3);
    next_cycle();
    req0 = 1'b0;
    @(negedge clk);
    check("rd_rvalid0", 32'(rvalid0), 32'd1);
    check("rd_rvalid1", 32'(rvalid1), 32'd0);
    check("rd_rdata", rdata, 32'h0000000D);
    next_cycle();

    // Round-robin on continuous unlocked reads.
    do_reset();
    req0 = 1'b1; addr0 = 4'd1;
    req1 = 1'b1; addr1 = 4'd2;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("rr_gnt0[%0d]", k), 32'(gnt0), 32'(k % 2 == 0));
      check($sformatf("rr_gnt1[%0d]", k), 32'(gnt1), 32'(k % 2 == 1));
      if (k > 0) begin
        check($sformatf("rr_rvalid0[%0d]", k), 32'(rvalid0), 32'(k % 2 == 1));
        check($sformatf("rr_rvalid1[%0d]", k), 32'(rvalid1), 32'(k % 2 == 0));
        check($sformatf("rr_rdata[%0d]", k), rdata, (k % 2 == 1) ? 32'd11 : 32'd12);
      end
      next_cycle();
    end
    drop_all();
    @(negedge clk);
    check("rr_last_rvalid1", 32'(rvalid1), 32'd1);
    check("rr_last_rdata", rdata, 32'd12);
    next_cycle();

    // Locked burst on port 0 capped at 4, then port 1, then a new burst.
    req0 = 1'b1; lock0 = 1'b1; req1 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check($sformatf("burst_gnt0[%0d]", k), 32'(gnt0), 32'(burst_exp[k]));
      check($sformatf("burst_gnt1[%0d]", k), 32'(gnt1), 32'(1 - burst_exp[k]));
      next_cycle();
    end
    drop_all();

    // Write then read back on port 1.
    do_reset();
    req1 = 1'b1; we1 = 1'b1; addr1 = 4'd7; wdata1 = 32'hDEADBEEF;
    @(negedge clk);
    check("wr_gnt1", 32'(gnt1), 32'd1);
    check("wr_ram_write", 32'(ram_write), 32'd1);
    check("wr_waddr", 32'(ram_write_address), 32'd7);
    check("wr_din", ram_din, 32'hDEADBEEF);
    next_cycle();
    we1 = 1'b0;
    @(negedge clk);
    check("wr_rd_gnt1", 32'(gnt1), 32'd1);
    check("wr_rd_ram_write", 32'(ram_write), 32'd0);
    check("wr_rd_rvalid1", 32'(rvalid1), 32'd0);
    next_cycle();
    req1 = 1'b0;
    @(negedge clk);
    check("wr_back_rvalid1", 32'(rvalid1), 32'd1);
    check("wr_back_rdata", rdata, 32'hDEADBEEF);
    check("wr_back_ram_write", 32'(ram_write), 32'd0);
    next_cycle();

    // Reset in the second cycle of a port-1 locked burst.
    req1 = 1'b1; lock1 = 1'b1; addr1 = 4'd4;
    @(negedge clk);
    check("mid_first_gnt1", 32'(gnt1), 32'd1);
    next_cycle();
    req0 = 1'b1; addr0 = 4'd5; rst = 1'b1;
    @(negedge clk);
    check("mid_rst_gnt0", 32'(gnt0), 32'd0);
    check("mid_rst_gnt1", 32'(gnt1), 32'd0);
    check("mid_rst_ram_write", 32'(ram_write), 32'd0);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check("mid_post_gnt0", 32'(gnt0), 32'd1);
    check("mid_post_gnt1", 32'(gnt1), 32'd0);
    check("mid_post_rvalid1", 32'(rvalid1), 32'd0);
    next_cycle();
    drop_all();

    // Idle: nothing granted, RAM outputs all zero.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("idle_gnt0[%0d]", k), 32'(gnt0), 32'd0);
      check($sformatf("idle_gnt1[%0d]", k), 32'(gnt1), 32'd0);
      check($sformatf("idle_ram_write[%0d]", k), 32'(ram_write), 32'd0);
      check($sformatf("idle_raddr[%0d]", k), 32'(ram_read_address), 32'd0);
      check($sformatf("idle_waddr[%0d]", k), 32'(ram_write_address), 32'd0);
      check($sformatf("idle_din[%0d]", k), ram_din, 32'd0);
      next_cycle();
    end
    // Back in idle with priority on port 1: a locked port 0 does not own.
    req0 = 1'b1; lock0 = 1'b1; req1 = 1'b1;
    @(negedge clk);
    check("idle_state_gnt1", 32'(gnt1), 32'd1);
    check("idle_state_gnt0", 32'(gnt0), 32'd0);
    next_cycle();
    drop_all();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
